// File: rtl/memc_lane_responder.sv
// memc_lane_responder
// -------------------
// Memory-controller responder for one PE lane's streaming-op DMA port. It
// arbitrates DMA write and read requests onto a single-port lane SRAM. Read
// data comes back through a small credit-limited FIFO that honours the DMA
// pause signal.
//
// Build option:
//   MEMC_RESP_RR_ARB_EN  defined   -> round-robin write/read arbitration
//                        undefined -> fixed write priority (default)
//
// Ports:
//   clk, reset_poweron                 lane clock, synchronous active-high reset
//   dma__memc__write_valid/_address/_data, memc__dma__write_ready
//                                      DMA write request channel
//   dma__memc__read_valid/_address, memc__dma__read_ready
//                                      DMA read request channel
//   dma__memc__read_pause              DMA cannot take return data this cycle
//   memc__dma__read_data/_data_valid   read return (valid means consumed)
//   memc__sram__enable/_write/_address/_write_data
//                                      SRAM strobe, all zero when idle
//   sram__memc__read_data              SRAM data, valid the cycle after a read
module memc_lane_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_poweron,
    input  logic                  dma__memc__write_valid,
    input  logic [ADDR_WIDTH-1:0] dma__memc__write_address,
    input  logic [DATA_WIDTH-1:0] dma__memc__write_data,
    output logic                  memc__dma__write_ready,
    input  logic                  dma__memc__read_valid,
    input  logic [ADDR_WIDTH-1:0] dma__memc__read_address,
    output logic                  memc__dma__read_ready,
    input  logic                  dma__memc__read_pause,
    output logic [DATA_WIDTH-1:0] memc__dma__read_data,
    output logic                  memc__dma__read_data_valid,
    output logic                  memc__sram__enable,
    output logic                  memc__sram__write,
    output logic [ADDR_WIDTH-1:0] memc__sram__address,
    output logic [DATA_WIDTH-1:0] memc__sram__write_data,
    input  logic [DATA_WIDTH-1:0] sram__memc__read_data
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

    logic           fifo_empty, fifo_full;
    logic [CNT_W:0] occupancy;
    logic           rd_credit;
    logic           wr_req, rd_req;
    logic           grant_wr, grant_rd;
    logic           push, pop;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));

    // A read accepted last cycle already owns a FIFO slot even though its data
    // has not been pushed yet, so it counts against the credit.
    assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign rd_credit = (occupancy < DEPTH_C);

    assign wr_req = dma__memc__write_valid && !reset_poweron;
    assign rd_req = dma__memc__read_valid && rd_credit && !reset_poweron;

`ifdef MEMC_RESP_RR_ARB_EN
    localparam logic ARB_WR = 1'b0;
    localparam logic ARB_RD = 1'b1;

    logic arb_ptr_q, arb_ptr_d;
    logic contended;

    // Only a contended cycle consults or moves the pointer.
    assign contended = wr_req && rd_req;
    assign grant_wr  = wr_req && (!contended || (arb_ptr_q == ARB_WR));
    assign grant_rd  = rd_req && (!contended || (arb_ptr_q == ARB_RD));
    assign arb_ptr_d = contended ? ~arb_ptr_q : arb_ptr_q;

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            arb_ptr_q <= ARB_WR;
        end else begin
            arb_ptr_q <= arb_ptr_d;
        end
    end
`else
    assign grant_wr = wr_req;
    assign grant_rd = rd_req && !wr_req;
`endif

    assign memc__dma__write_ready = grant_wr;
    assign memc__dma__read_ready  = grant_rd;

    assign memc__sram__enable     = grant_wr || grant_rd;
    assign memc__sram__write      = grant_wr;
    assign memc__sram__address    = grant_wr ? dma__memc__write_address :
                                    grant_rd ? dma__memc__read_address  : '0;
    assign memc__sram__write_data = grant_wr ? dma__memc__write_data : '0;

    // SRAM data for last cycle's read lands in the FIFO at the end of this one.
    assign push = inflight_q;
    assign pop  = !fifo_empty && !dma__memc__read_pause && !reset_poweron;

    assign memc__dma__read_data_valid = pop;
    // Stale storage is never visible: an empty FIFO presents zero.
    assign memc__dma__read_data = fifo_empty ? '0 : fifo_mem[rd_ptr_q];

    always_comb begin
        inflight_d = grant_rd;
        wr_ptr_d   = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d   = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            // Credit accounting makes a push into a full FIFO impossible.
            assert (!(push && fifo_full));
        end
    end

    // Storage carries no reset; the pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (push && !reset_poweron) begin
            fifo_mem[wr_ptr_q] <= sram__memc__read_data;
        end
    end

endmodule

// File: tb/tb_memc_lane_responder.sv
module tb_memc_lane_responder;

    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_poweron;
    logic          write_valid;
    logic [AW-1:0] write_address;
    logic [DW-1:0] write_data;
    logic          write_ready;
    logic          read_valid;
    logic [AW-1:0] read_address;
    logic          read_ready;
    logic          read_pause;
    logic [DW-1:0] read_data;
    logic          read_data_valid;
    logic          sram_en;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    memc_lane_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk                        (clk),
        .reset_poweron              (reset_poweron),
        .dma__memc__write_valid     (write_valid),
        .dma__memc__write_address   (write_address),
        .dma__memc__write_data      (write_data),
        .memc__dma__write_ready     (write_ready),
        .dma__memc__read_valid      (read_valid),
        .dma__memc__read_address    (read_address),
        .memc__dma__read_ready      (read_ready),
        .dma__memc__read_pause      (read_pause),
        .memc__dma__read_data       (read_data),
        .memc__dma__read_data_valid (read_data_valid),
        .memc__sram__enable         (sram_en),
        .memc__sram__write          (sram_we),
        .memc__sram__address        (sram_addr),
        .memc__sram__write_data     (sram_wdata),
        .sram__memc__read_data      (sram_rdata)
    );

    always #5 clk = ~clk;

    // Lane SRAM: write at the edge, read data registered one cycle later.
    bit [DW-1:0] sram_mem [int];
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) sram_mem[int'(sram_addr)] = sram_wdata;
            else         sram_rdata <= sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : '0;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a flat memory image plus an ordered list of expected
    // returns, each tagged with the earliest cycle it may appear.
    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    bit [DW-1:0] ref_mem [int];
    exp_t        exp_q [$];
    int          cyc = 0;
    int          n_ret = 0;
    bit          post_reset = 0;
    bit          rr_ptr_rd = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / scoreboard: predicts grants and returns from the request
    // stream and the model, then compares with what the DUT presents.
    always @(negedge clk) begin
        logic ew, er, ev;
        if (reset_poweron) begin
            chk("rst_write_ready", write_ready, 0);
            chk("rst_read_ready", read_ready, 0);
            chk("rst_sram_enable", sram_en, 0);
            exp_q.delete();
            post_reset = 1;
            rr_ptr_rd  = 0;
        end else begin
            if (post_reset) begin
                chk("post_rst_read_data", read_data, 0);
                chk("post_rst_valid", read_data_valid, 0);
                post_reset = 0;
            end
            ew = write_valid;
            er = read_valid && (exp_q.size() < DEPTH);
            if (ew && er) begin
`ifdef MEMC_RESP_RR_ARB_EN
                if (rr_ptr_rd) ew = 0;
                else           er = 0;
                rr_ptr_rd = !rr_ptr_rd;
`else
                er = 0;
`endif
            end
            chk("write_ready", write_ready, ew);
            chk("read_ready", read_ready, er);
            chk("sram_enable", sram_en, ew || er);
            chk("sram_write", sram_we, ew);
            if (ew) begin
                chk("sram_waddr", sram_addr, write_address);
                chk("sram_wdata", sram_wdata, write_data);
            end else if (er) begin
                chk("sram_raddr", sram_addr, read_address);
            end else begin
                chk("sram_idle_addr", sram_addr, 0);
                chk("sram_idle_wdata", sram_wdata, 0);
            end
            ev = (exp_q.size() > 0) && (exp_q[0].due <= cyc) && !read_pause;
            chk("read_data_valid", read_data_valid, ev);
            if (ev) begin
                chk("read_data", read_data, exp_q[0].data);
                void'(exp_q.pop_front());
                n_ret++;
            end
            if (ew) ref_mem[int'(write_address)] = write_data;
            if (er) exp_q.push_back('{ref_mem.exists(int'(read_address)) ? ref_mem[int'(read_address)] : '0, cyc + 2});
        end
    end

    logic last_wg, last_rg;

    task automatic drive(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic rv, input logic [AW-1:0] ra, input logic ps);
        write_valid   = wv;
        write_address = wa;
        write_data    = wd;
        read_valid    = rv;
        read_address  = ra;
        read_pause    = ps;
        @(negedge clk);
        last_wg = write_valid && write_ready;
        last_rg = read_valid && read_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic ps);
        for (int i = 0; i < n; i++) drive(0, '0, '0, 0, '0, ps);
    endtask

    initial begin
        int acc, lat, ret0, iter;
        logic [3:0] wmask, rmask;
        logic found;
        reset_poweron = 1;
        write_valid = 0; write_address = '0; write_data = '0;
        read_valid = 0; read_address = '0; read_pause = 0;
        repeat (3) @(posedge clk);
        #1;
        reset_poweron = 0;
        idle(2, 0);

        // Write then read the same address on consecutive cycles.
        drive(1, 12'h010, 32'hDEADBEEF, 0, '0, 0);
        drive(0, '0, '0, 1, 12'h010, 0);
        chk("wr_rd_read_accepted", last_rg, 1);
        lat = 1; found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (read_data_valid) begin
                found = 1;
                chk("wr_rd_latency", lat, 2);
                chk("wr_rd_data", read_data, 32'hDEADBEEF);
            end else begin
                lat++;
            end
            @(posedge clk);
            #1;
        end
        chk("wr_rd_returned", found, 1);
        idle(2, 0);

        // Back-to-back reads of 0..7.
        for (int i = 0; i < 8; i++) drive(1, AW'(i), $urandom, 0, '0, 0);
        ret0 = n_ret;
        for (int i = 0; i < 8; i++) drive(0, '0, '0, 1, AW'(i), 0);
        idle(6, 0);
        chk("b2b_returns", n_ret - ret0, 8);

        // Pause holds returns; credit stops reads after DEPTH outstanding.
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            drive(0, '0, '0, 1, AW'(32 + i), 1);
            if (last_rg) acc++;
        end
        chk("pause_accepted", acc, DEPTH);
        ret0 = n_ret;
        idle(8, 0);
        chk("pause_drained", n_ret - ret0, DEPTH);

        // Contention for four cycles.
        wmask = '0; rmask = '0;
        for (int i = 0; i < 4; i++) begin
            drive(1, AW'(64 + i), $urandom, 1, AW'(i), 0);
            wmask[i] = last_wg;
            rmask[i] = last_rg;
        end
`ifdef MEMC_RESP_RR_ARB_EN
        chk("contend_wmask", wmask, 4'b0101);
        chk("contend_rmask", rmask, 4'b1010);
`else
        chk("contend_wmask", wmask, 4'b1111);
        chk("contend_rmask", rmask, 4'b0000);
`endif
        idle(6, 0);

        // Reset with three reads outstanding behind a pause.
        for (int i = 0; i < 3; i++) drive(0, '0, '0, 1, AW'(i), 1);
        reset_poweron = 1;
        idle(1, 1);
        reset_poweron = 0;
        ret0 = n_ret;
        idle(6, 0);
        chk("post_reset_no_returns", n_ret - ret0, 0);

        // Randomized traffic with pause toggling every cycle.
        acc = 0; iter = 0;
        while (acc < 100 && iter < 3000) begin
            drive(($urandom % 3) == 0, AW'($urandom_range(0, 15)), $urandom,
                  ($urandom % 4) != 0, AW'($urandom_range(0, 15)), iter[0]);
            if (last_rg) acc++;
            iter++;
        end
        chk("random_reads_done", acc >= 100, 1);
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) idle(1, 0);
        chk("drain_empty", exp_q.size(), 0);
        idle(2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
